// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data wins over fetch, bounded by a streak guard; fixed memory latency.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LAT        = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int SW = $clog2(MAX_STREAK + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [SW-1:0]   r_streak, w_streak;
  logic            r_own_d, w_own_d;
  logic            r_mem_en, w_mem_en;
  logic            r_mem_we, w_mem_we;
  logic [AW-1:0]   r_mem_addr, w_mem_addr;
  logic [DW-1:0]   r_mem_wdata, w_mem_wdata;
  logic [DW-1:0]   r_i_rdata, w_i_rdata;
  logic [DW-1:0]   r_d_rdata, w_d_rdata;
  logic            r_i_ack, w_i_ack;
  logic            r_d_ack, w_d_ack;
  logic            r_busy, w_busy;
  logic            w_grant_d;
  logic            w_sat;

  assign w_sat     = (r_streak == SW'(MAX_STREAK));
  // Fetch only overtakes a pending data request once the streak saturates
  assign w_grant_d = d_req && !(i_req && w_sat);

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_streak    = r_streak;
    w_own_d     = r_own_d;
    w_mem_en    = r_mem_en;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_i_rdata   = r_i_rdata;
    w_d_rdata   = r_d_rdata;
    w_i_ack     = 1'b0;
    w_d_ack     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_req || d_req) begin
          w_state  = BUSY;
          w_mem_en = 1'b1;
          w_cnt    = CW'(LAT - 1);
          w_own_d  = w_grant_d;
          if (w_grant_d) begin
            w_mem_we    = d_we;
            w_mem_addr  = d_addr;
            w_mem_wdata = d_wdata;
            if (!i_req)
              w_streak = '0;
            else if (!w_sat)
              w_streak = r_streak + SW'(1);
          end else begin
            w_mem_we   = 1'b0;
            w_mem_addr = i_addr;
            w_streak   = '0;
          end
        end
      end
      BUSY: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - CW'(1);
        end else begin
          w_state  = DONE;
          w_mem_en = 1'b0;
          w_mem_we = 1'b0;
          if (r_own_d) begin
            w_d_ack = 1'b1;
            if (!r_mem_we)
              w_d_rdata = mem_rdata;
          end else begin
            w_i_ack   = 1'b1;
            w_i_rdata = mem_rdata;
          end
        end
      end
      DONE:    w_state = IDLE;
      default: w_state = IDLE;
    endcase
    w_busy = (w_state != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_streak    <= '0;
      r_own_d     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_streak    <= w_streak;
      r_own_d     <= w_own_d;
      r_mem_en    <= w_mem_en;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_i_rdata   <= w_i_rdata;
      r_d_rdata   <= w_d_rdata;
      r_i_ack     <= w_i_ack;
      r_d_ack     <= w_d_ack;
      r_busy      <= w_busy;
    end
  end

  assign i_rdata   = r_i_rdata;
  assign i_ack     = r_i_ack;
  assign d_rdata   = r_d_rdata;
  assign d_ack     = r_d_ack;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random fetch/data traffic against a transaction-level arbiter model.
// Memory returns junk except in the last cycle of an access.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int MS  = 2;
  localparam int NCYC = 3000;

  logic          CLK;
  logic          Reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .LAT(LAT), .MAX_STREAK(MS)
  ) dut (
    .CLK(CLK), .Reset(Reset),
    .i_req(i_req), .i_addr(i_addr),
    .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] seed_word(input int i);
    return 32'hA500_0000 + 32'(i) * 32'h0001_1111;
  endfunction

  // Behavioural memory: data only valid in the LAT-th enabled cycle
  logic [DW-1:0] bmem [16];
  logic [DW-1:0] junk;
  int            en_age;
  bit            fill;

  always @(posedge CLK) begin
    if (fill)
      for (int i = 0; i < 16; i++) bmem[i] <= seed_word(i);
    else if (mem_en && mem_we && en_age == LAT - 1)
      bmem[mem_addr[5:2]] <= mem_wdata;
    en_age <= mem_en ? en_age + 1 : 0;
  end

  always @(negedge CLK) junk <= $urandom;

  assign mem_rdata = (mem_en && en_age == LAT - 1) ?
                     bmem[mem_addr[5:2]] : junk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // Reference model: one transaction at a time, timed by edge index
  logic [DW-1:0] ref_mem [16];
  bit            have_txn;
  int            g;
  bit            t_d;
  bit            t_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata;
  int            streak;
  logic [DW-1:0] exp_ird;
  logic [DW-1:0] exp_drd;
  logic [AW-1:0] exp_addr;
  bit            act;
  bit            ack;
  bit            bsy;

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = seed_word(i);
    have_txn = 0; g = 0; streak = 0;
    exp_ird = '0; exp_drd = '0; exp_addr = '0;
    fill = 1'b1;
    Reset = 1'b1;
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h20; d_wdata = 32'h55;

    for (int e = 0; e < NCYC; e++) begin
      @(posedge CLK);
      #1;
      fill = 1'b0;

      if (Reset) begin
        have_txn = 0;
        streak   = 0;
        exp_ird  = '0;
        exp_drd  = '0;
        exp_addr = '0;
      end else begin
        if (have_txn && e == g + LAT) begin
          if (t_we)
            ref_mem[t_addr[5:2]] = t_wdata;
          else if (t_d)
            exp_drd = ref_mem[t_addr[5:2]];
          else
            exp_ird = ref_mem[t_addr[5:2]];
        end
        if ((!have_txn || e >= g + LAT + 2) && (i_req || d_req)) begin
          t_d = d_req && !(i_req && streak == MS);
          if (t_d) begin
            t_we    = d_we;
            t_addr  = d_addr;
            t_wdata = d_wdata;
            streak  = i_req ? ((streak < MS) ? streak + 1 : MS) : 0;
          end else begin
            t_we   = 1'b0;
            t_addr = i_addr;
            streak = 0;
          end
          g        = e;
          have_txn = 1;
          exp_addr = t_addr;
        end
      end

      act = have_txn && (e <= g + LAT - 1);
      ack = have_txn && (e == g + LAT);
      bsy = have_txn && (e <= g + LAT);

      chk("mem_en",   32'(mem_en),  32'(act));
      chk("mem_we",   32'(mem_we),  32'(act && t_we));
      chk("busy",     32'(busy),    32'(bsy));
      chk("i_ack",    32'(i_ack),   32'(ack && !t_d));
      chk("d_ack",    32'(d_ack),   32'(ack && t_d));
      chk("i_rdata",  i_rdata,      exp_ird);
      chk("d_rdata",  d_rdata,      exp_drd);
      chk("mem_addr", mem_addr,     exp_addr);
      if (act && t_we)
        chk("mem_wdata", mem_wdata, t_wdata);
      if (Reset)
        chk("rst_wdata", mem_wdata, 32'h0);

      // Requesters drop req on seeing ack, then re-request at random
      if (ack && !t_d) i_req = 1'b0;
      else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req  = 1'b1;
        i_addr = $urandom;
      end
      if (ack && t_d) d_req = 1'b0;
      else if (!d_req && $urandom_range(0, 3) != 0) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom;
        d_wdata = $urandom;
      end

      if (Reset) begin
        if (e >= 1) Reset = 1'b0;
      end else if (e > 4 && $urandom_range(0, 49) == 0) begin
        if (!have_txn || e + 1 != g + LAT) Reset = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
